// File: rtl/or1200_vlx_packer.sv
// Variable-length bit packer for the OR1200 VLX unit.
// Codes are packed MSB-first into an accumulator, whole bytes are moved to a
// small byte FIFO (with optional FF->FF00 stuffing) and streamed out as byte
// stores through a request/ack handshake at an auto-incrementing address.
module or1200_vlx_packer #(
  parameter int ACC_W      = 32,
  parameter int MAX_BITS   = 16,
  parameter int FIFO_DEPTH = 4,
  parameter int NB_W       = $clog2(MAX_BITS + 1)
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            set_bit_op_i,
  input  logic [NB_W-1:0] num_bits_to_write_i,
  input  logic [31:0]     dat_i,
  input  logic            spr_cs,
  input  logic            spr_write,
  input  logic [1:0]      spr_addr,
  input  logic [31:0]     spr_dat_i,
  output logic [31:0]     spr_dat_o,
  output logic            stall_cpu_o,
  output logic            store_byte_o,
  output logic [31:0]     vlx_addr_o,
  output logic [31:0]     dat_o,
  input  logic            ack_i
);

  localparam int CNT_W = $clog2(ACC_W + 1);
  localparam int SUM_W = CNT_W + 1;
  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int LVL_W = PTR_W + 1;
  localparam int CW    = (ACC_W > 32) ? ACC_W : 32;

  // Packing state
  logic [ACC_W-1:0] acc_reg, acc_next;
  logic [CNT_W-1:0] cnt_reg, cnt_next;

  // Byte FIFO
  logic [7:0]       fifo_mem [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr_reg, rd_ptr_reg;
  logic [LVL_W-1:0] level_reg;

  // Control / address state
  logic        flushing_reg, stuff_en_reg, pend_valid_reg;
  logic [31:0] pend_addr_reg, addr_reg;

  // Combinational helpers
  logic             spr_wr, ctrl_wr, addr_wr;
  logic [SUM_W-1:0] sum_len, cnt_sum;
  logic             accept, extract, stuff, pop, pad, busy;
  logic [LVL_W-1:0] free_cnt, push_n;
  logic [PTR_W-1:0] wr_ptr_plus1;
  logic [7:0]       ext_byte;
  logic [3:0]       pad_p;
  logic [CW-1:0]    code_mask;
  logic [ACC_W-1:0] code, pad_ones;

  assign spr_wr  = spr_cs & spr_write;
  assign ctrl_wr = spr_wr & (spr_addr == 2'b01);
  assign addr_wr = spr_wr & spr_addr[1];

  assign sum_len  = SUM_W'(cnt_reg) + SUM_W'(num_bits_to_write_i);
  assign accept   = set_bit_op_i & (sum_len <= SUM_W'(ACC_W)) & ~flushing_reg;
  assign free_cnt = LVL_W'(FIFO_DEPTH) - level_reg;
  // Always reserve room for a possible FF/00 pair so the pair is never split.
  assign extract  = (cnt_reg >= CNT_W'(8)) & (free_cnt >= LVL_W'(2));
  assign ext_byte = 8'(acc_reg >> (cnt_reg - CNT_W'(8)));
  assign stuff    = extract & stuff_en_reg & (ext_byte == 8'hFF);
  assign push_n   = extract ? (stuff ? LVL_W'(2) : LVL_W'(1)) : LVL_W'(0);
  assign wr_ptr_plus1 = wr_ptr_reg + PTR_W'(1);

  assign store_byte_o = (level_reg != '0);
  assign pop          = store_byte_o & ack_i;

  assign code_mask = (CW'(1) << num_bits_to_write_i) - CW'(1);
  assign code      = ACC_W'(CW'(dat_i) & code_mask);

  // Padding to the next byte boundary; allowed only if the shifted-out top
  // bits are either unused or leave through extraction in the same cycle.
  assign pad_p    = 4'd8 - {1'b0, cnt_reg[2:0]};
  assign pad_ones = (ACC_W'(1) << pad_p) - ACC_W'(1);
  assign pad      = flushing_reg & (cnt_reg[2:0] != 3'd0) &
                    ((SUM_W'(cnt_reg) + SUM_W'(pad_p) <= SUM_W'(ACC_W)) | extract);

  assign busy        = (cnt_reg != '0) | store_byte_o | flushing_reg;
  assign stall_cpu_o = (set_bit_op_i & ~accept) | flushing_reg;
  assign vlx_addr_o  = addr_reg;
  assign dat_o       = store_byte_o ? {24'b0, fifo_mem[rd_ptr_reg]} : 32'b0;

  // SPR read mux: status, write-only control reads zero, address register.
  always_comb begin
    spr_dat_o = 32'b0;
    case (spr_addr)
      2'b00:   spr_dat_o = {16'b0, 8'(cnt_reg), 7'(level_reg), busy};
      2'b01:   spr_dat_o = 32'b0;
      default: spr_dat_o = addr_reg;
    endcase
  end

  // Next accumulator/count: accept or pad appends bits, extraction removes 8.
  always_comb begin
    acc_next = acc_reg;
    cnt_sum  = SUM_W'(cnt_reg);
    if (accept) begin
      acc_next = (acc_reg << num_bits_to_write_i) | code;
      cnt_sum  = sum_len;
    end else if (pad) begin
      acc_next = (acc_reg << pad_p) | pad_ones;
      cnt_sum  = SUM_W'(cnt_reg) + SUM_W'(pad_p);
    end
    if (extract) begin
      cnt_sum = cnt_sum - SUM_W'(8);
    end
    cnt_next = CNT_W'(cnt_sum);
  end

  // Accumulator and bit count registers.
  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      acc_reg <= '0;
      cnt_reg <= '0;
    end else begin
      acc_reg <= acc_next;
      cnt_reg <= cnt_next;
    end
  end

  // FIFO storage: extracted byte plus optional stuffed 00 in the next slot.
  always_ff @(posedge clk_i) begin
    if (extract) begin
      fifo_mem[wr_ptr_reg] <= ext_byte;
    end
    if (stuff) begin
      fifo_mem[wr_ptr_plus1] <= 8'h00;
    end
  end

  // FIFO pointers and level; push and pop may coincide.
  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      level_reg  <= '0;
    end else begin
      wr_ptr_reg <= wr_ptr_reg + PTR_W'(push_n);
      if (pop) begin
        rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);
      end
      level_reg <= level_reg + push_n - (pop ? LVL_W'(1) : LVL_W'(0));
    end
  end

  // Store address: direct write, deferred write while a store waits, or +1.
  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      addr_reg       <= 32'b0;
      pend_addr_reg  <= 32'b0;
      pend_valid_reg <= 1'b0;
    end else if (addr_wr && (!store_byte_o || ack_i)) begin
      addr_reg       <= spr_dat_i;
      pend_valid_reg <= 1'b0;
    end else if (addr_wr) begin
      pend_addr_reg  <= spr_dat_i;
      pend_valid_reg <= 1'b1;
    end else if (pop) begin
      addr_reg       <= pend_valid_reg ? pend_addr_reg : addr_reg + 32'd1;
      pend_valid_reg <= 1'b0;
    end
  end

  // Control flags: stuffing enable and the flush sequence flag.
  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      stuff_en_reg <= 1'b1;
      flushing_reg <= 1'b0;
    end else begin
      if (ctrl_wr) begin
        stuff_en_reg <= spr_dat_i[1];
      end
      if (ctrl_wr && spr_dat_i[0]) begin
        flushing_reg <= 1'b1;
      end else if (flushing_reg && (cnt_reg == '0) && !store_byte_o && !pend_valid_reg) begin
        flushing_reg <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_or1200_vlx_packer.sv
// Directed bench for or1200_vlx_packer with an expected-store scoreboard.
module tb_or1200_vlx_packer;

  localparam int NB_W = 5;

  logic            clk = 1'b0;
  logic            rst_i;
  logic            set_bit_op_i;
  logic [NB_W-1:0] num_bits_to_write_i;
  logic [31:0]     dat_i;
  logic            spr_cs, spr_write;
  logic [1:0]      spr_addr;
  logic [31:0]     spr_dat_i;
  logic [31:0]     spr_dat_o;
  logic            stall_cpu_o;
  logic            store_byte_o;
  logic [31:0]     vlx_addr_o;
  logic [31:0]     dat_o;
  logic            ack_i;

  int n_checks = 0;
  int n_fail   = 0;

  // Expected stores {addr, byte}, pushed when the stimulus is driven.
  logic [39:0] exp_q[$];
  logic [31:0] exp_addr;

  // Observed stores, written only by the monitor.
  logic [31:0] obs_data [256];
  logic [31:0] obs_addr [256];
  int          obs_n = 0;
  int          rd_idx = 0;

  or1200_vlx_packer dut (
    .clk_i               (clk),
    .rst_i               (rst_i),
    .set_bit_op_i        (set_bit_op_i),
    .num_bits_to_write_i (num_bits_to_write_i),
    .dat_i               (dat_i),
    .spr_cs              (spr_cs),
    .spr_write           (spr_write),
    .spr_addr            (spr_addr),
    .spr_dat_i           (spr_dat_i),
    .spr_dat_o           (spr_dat_o),
    .stall_cpu_o         (stall_cpu_o),
    .store_byte_o        (store_byte_o),
    .vlx_addr_o          (vlx_addr_o),
    .dat_o               (dat_o),
    .ack_i               (ack_i)
  );

  always #5 clk = ~clk;

  // Record every acknowledged store (one line per transaction).
  always @(negedge clk) begin
    if (rst_i && store_byte_o && ack_i && obs_n < 256) begin
      obs_data[obs_n] = dat_o;
      obs_addr[obs_n] = vlx_addr_o;
      $display("store byte %02h @ %08h", dat_o[7:0], vlx_addr_o);
      obs_n = obs_n + 1;
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic push_exp(input logic [7:0] b);
    exp_q.push_back({exp_addr, b});
    exp_addr = exp_addr + 32'd1;
  endtask

  // Compare every newly observed store against the head of the scoreboard.
  task automatic score();
    logic [39:0] e;
    while (rd_idx < obs_n) begin
      n_checks++;
      assert (exp_q.size() != 0) else begin
        n_fail++;
        $error("FAIL unexpected_store: observed %h@%h expected none", obs_data[rd_idx], obs_addr[rd_idx]);
      end
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        check("store_data", obs_data[rd_idx], {24'b0, e[7:0]});
        check("store_addr", obs_addr[rd_idx], e[39:8]);
      end
      rd_idx++;
    end
  endtask

  task automatic spr_wr(input logic [1:0] a, input logic [31:0] d);
    spr_cs = 1'b1; spr_write = 1'b1; spr_addr = a; spr_dat_i = d;
    cyc();
    spr_cs = 1'b0; spr_write = 1'b0;
  endtask

  task automatic spr_rd(input logic [1:0] a, output logic [31:0] d);
    spr_addr = a;
    #1;
    d = spr_dat_o;
  endtask

  // Issue one set-bit operation and hold it until the DUT accepts it.
  task automatic do_op(input int len, input logic [31:0] val, output int stalls);
    logic ok;
    ok = 1'b0;
    stalls = 0;
    set_bit_op_i = 1'b1; num_bits_to_write_i = NB_W'(len); dat_i = val;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (!stall_cpu_o) begin ok = 1'b1; break; end
      stalls++;
    end
    @(posedge clk);
    #1;
    set_bit_op_i = 1'b0;
    check("op_accept", {31'b0, ok}, 32'd1);
  endtask

  // Acknowledge every cycle until the scoreboard and the FIFO are empty.
  task automatic drain();
    logic done;
    done = 1'b0;
    ack_i = 1'b1;
    for (int i = 0; i < 200; i++) begin
      cyc();
      score();
      if (exp_q.size() == 0 && !store_byte_o) begin done = 1'b1; break; end
    end
    ack_i = 1'b0;
    check("drain_done", {31'b0, done}, 32'd1);
  endtask

  initial begin
    logic [31:0] rd;
    logic [15:0] vals [8];
    int st, st_total;

    rst_i = 1'b0; set_bit_op_i = 1'b0; num_bits_to_write_i = '0; dat_i = '0;
    spr_cs = 1'b0; spr_write = 1'b0; spr_addr = 2'b00; spr_dat_i = '0; ack_i = 1'b0;
    exp_addr = 32'h0;
    repeat (3) cyc();

    // Reset state
    check("rst_store", {31'b0, store_byte_o}, 32'd0);
    check("rst_stall", {31'b0, stall_cpu_o}, 32'd0);
    check("rst_dat", dat_o, 32'd0);
    check("rst_addr", vlx_addr_o, 32'd0);
    spr_rd(2'b00, rd); check("rst_status", rd, 32'd0);
    rst_i = 1'b1;
    cyc();

    // Packing: A,5 nibbles then 3C byte
    spr_wr(2'b10, 32'h0000_1000);
    check("addr_write", vlx_addr_o, 32'h0000_1000);
    exp_addr = 32'h1000;
    push_exp(8'hA5); push_exp(8'h3C);
    st_total = 0;
    do_op(4, 32'hFFFF_FFFA, st); st_total += st;
    do_op(4, 32'h0000_0005, st); st_total += st;
    do_op(8, 32'h0000_013C, st); st_total += st;
    check("pack_no_stall", 32'(st_total), 32'd0);
    cyc(); cyc();
    spr_rd(2'b00, rd); check("pack_status", rd, 32'h0000_0005);
    drain();
    check("pack_addr_after", vlx_addr_o, 32'h0000_1002);

    // Stuffing enabled, then disabled
    push_exp(8'hFF); push_exp(8'h00);
    do_op(8, 32'h0000_00FF, st);
    drain();
    spr_wr(2'b01, 32'h0);
    push_exp(8'hFF);
    do_op(8, 32'h0000_00FF, st);
    drain();
    spr_wr(2'b01, 32'h2);

    // Flush: 101 padded with ones
    push_exp(8'hBF);
    do_op(3, 32'h0000_0005, st);
    spr_wr(2'b01, 32'h3);
    repeat (3) cyc();
    check("flush_stall", {31'b0, stall_cpu_o}, 32'd1);
    check("flush_dat", dat_o, 32'h0000_00BF);
    spr_rd(2'b00, rd); check("flush_status", rd, 32'h0000_0003);
    drain();
    cyc(); cyc();
    spr_rd(2'b00, rd); check("flush_idle_status", rd, 32'd0);
    check("flush_stall_clr", {31'b0, stall_cpu_o}, 32'd0);

    // Back-pressure: eight 16-bit ops with ack held low at first
    for (int i = 0; i < 8; i++) vals[i] = 16'h1234 + 16'(i) * 16'h1111;
    for (int i = 0; i < 8; i++) begin push_exp(vals[i][15:8]); push_exp(vals[i][7:0]); end
    do_op(16, {16'hABCD, vals[0]}, st);
    do_op(16, {16'h0000, vals[1]}, st);
    do_op(16, {16'h0000, vals[2]}, st);
    check("bp_op3_stalls", 32'(st), 32'd1);
    set_bit_op_i = 1'b1; num_bits_to_write_i = NB_W'(16); dat_i = {16'h0, vals[3]};
    repeat (10) cyc();
    check("bp_stall", {31'b0, stall_cpu_o}, 32'd1);
    check("bp_head", dat_o, 32'h0000_0012);
    spr_rd(2'b00, rd); check("bp_status", rd, 32'h0000_1807);
    ack_i = 1'b1;
    for (int i = 3; i < 8; i++) do_op(16, {16'h0, vals[i]}, st);
    drain();

    // Pending address write while a store waits unacknowledged
    spr_wr(2'b10, 32'h0000_1003);
    exp_addr = 32'h1003;
    push_exp(8'h11);
    exp_addr = 32'h2000;
    push_exp(8'h22);
    do_op(8, 32'h11, st);
    do_op(8, 32'h22, st);
    repeat (3) cyc();
    spr_wr(2'b10, 32'h0000_2000);
    check("pend_addr_hold", vlx_addr_o, 32'h0000_1003);
    check("pend_dat_hold", dat_o, 32'h0000_0011);
    spr_rd(2'b10, rd); check("pend_addr_read", rd, 32'h0000_1003);
    drain();
    check("pend_addr_after", vlx_addr_o, 32'h0000_2001);

    // Reset mid-stream with three bytes queued
    do_op(8, 32'h31, st);
    do_op(8, 32'h32, st);
    do_op(8, 32'h33, st);
    repeat (3) cyc();
    spr_rd(2'b00, rd); check("pre_rst_status", rd, 32'h0000_0007);
    check("pre_rst_store", {31'b0, store_byte_o}, 32'd1);
    rst_i = 1'b0;
    cyc();
    rst_i = 1'b1;
    check("mid_rst_store", {31'b0, store_byte_o}, 32'd0);
    spr_rd(2'b00, rd); check("mid_rst_status", rd, 32'd0);
    check("mid_rst_addr", vlx_addr_o, 32'd0);
    check("mid_rst_dat", dat_o, 32'd0);
    ack_i = 1'b1;
    repeat (10) cyc();
    ack_i = 1'b0;
    score();
    check("post_rst_store", {31'b0, store_byte_o}, 32'd0);
    check("missing_stores", 32'(exp_q.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
